// File: rtl/bsg_manycore_link_mem_responder.sv
// Cache-less memory endpoint for a manycore edge link: serves fwd load/store requests from a word SRAM.
// Store acks carry data 0. link_sif = {fwd{v,ready_and,pkt}, rev{v,ready_and,pkt}}; packet layouts in the structs below.
module bsg_manycore_link_mem_responder #(
    parameter int addr_width_p   = 28,
    parameter int data_width_p   = 32,
    parameter int x_cord_width_p = 4,
    parameter int y_cord_width_p = 4,
    parameter int els_p          = 1024,
    localparam int link_sif_width_lp =
        (addr_width_p + 2 + data_width_p/8 + 5 + data_width_p + 2*(x_cord_width_p + y_cord_width_p) + 2)
      + (2 + data_width_p + 5 + 2*(x_cord_width_p + y_cord_width_p) + 2)
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic [link_sif_width_lp-1:0] link_sif_i,
    output logic [link_sif_width_lp-1:0] link_sif_o,
    input  logic [x_cord_width_p-1:0]    my_x_i,
    input  logic [y_cord_width_p-1:0]    my_y_i,
    output logic [15:0]                  err_count_o
);

    localparam int mask_w_lp  = data_width_p / 8;
    localparam int reg_w_lp   = 5;
    localparam int fwd_w_lp   = addr_width_p + 2 + mask_w_lp + reg_w_lp + data_width_p
                              + 2*(x_cord_width_p + y_cord_width_p);
    localparam int ret_w_lp   = 2 + data_width_p + reg_w_lp + 2*(x_cord_width_p + y_cord_width_p);
    localparam int idx_w_lp   = $clog2(els_p);

    localparam logic [1:0] OP_STORE  = 2'd1;
    localparam logic [1:0] RET_LOAD  = 2'd0;
    localparam logic [1:0] RET_WACK  = 2'd1;

    typedef struct packed {
        logic [addr_width_p-1:0]   addr;
        logic [1:0]                op;
        logic [mask_w_lp-1:0]      mask;
        logic [reg_w_lp-1:0]       reg_id;
        logic [data_width_p-1:0]   payload;
        logic [y_cord_width_p-1:0] src_y;
        logic [x_cord_width_p-1:0] src_x;
        logic [y_cord_width_p-1:0] dst_y;
        logic [x_cord_width_p-1:0] dst_x;
    } fwd_pkt_s;

    typedef struct packed {
        logic [1:0]                pkt_type;
        logic [data_width_p-1:0]   data;
        logic [reg_w_lp-1:0]       reg_id;
        logic [y_cord_width_p-1:0] src_y;
        logic [x_cord_width_p-1:0] src_x;
        logic [y_cord_width_p-1:0] dst_y;
        logic [x_cord_width_p-1:0] dst_x;
    } ret_pkt_s;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP} state_e;

    state_e                  r_state;
    logic                    r_fwd_ready;
    logic                    r_rev_v;
    ret_pkt_s                r_ret;
    logic [15:0]             r_err_count;
    logic [data_width_p-1:0] r_mem [els_p];
    logic [data_width_p-1:0] r_rdata;

    logic                    w_fwd_v;
    fwd_pkt_s                w_req;
    logic                    w_rev_ready;
    logic                    w_accept;
    logic                    w_legal;
    logic                    w_is_store;
    logic [idx_w_lp-1:0]     w_idx;
    logic                    w_unused;

    assign w_fwd_v     = link_sif_i[link_sif_width_lp-1];
    assign w_req       = fwd_pkt_s'(link_sif_i[link_sif_width_lp-3 -: fwd_w_lp]);
    assign w_rev_ready = link_sif_i[ret_w_lp];
    assign w_unused    = ^{link_sif_i[link_sif_width_lp-2], link_sif_i[ret_w_lp+1],
                           link_sif_i[ret_w_lp-1:0], w_req.dst_x, w_req.dst_y};

    assign w_accept   = r_fwd_ready & w_fwd_v;
    assign w_legal    = w_req.addr < addr_width_p'(els_p);
    assign w_is_store = (w_req.op == OP_STORE);
    assign w_idx      = w_req.addr[idx_w_lp-1:0];

    // Outgoing fwd valid is never raised; incoming rev traffic is always sunk.
    assign link_sif_o  = {1'b0, r_fwd_ready, {fwd_w_lp{1'b0}}, r_rev_v, 1'b1, r_ret};
    assign err_count_o = r_err_count;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= S_IDLE;
            r_fwd_ready <= 1'b0;
            r_rev_v     <= 1'b0;
            r_ret       <= '0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_fwd_ready <= ~w_accept;
                    if (w_accept) begin
                        r_ret.reg_id <= w_req.reg_id;
                        r_ret.dst_x  <= w_req.src_x;
                        r_ret.dst_y  <= w_req.src_y;
                        r_ret.src_x  <= my_x_i;
                        r_ret.src_y  <= my_y_i;
                        r_ret.data   <= '0;
                        if (!w_legal && r_err_count != 16'hFFFF)
                            r_err_count <= r_err_count + 16'd1;
                        if (w_is_store) begin
                            r_ret.pkt_type <= RET_WACK;
                            r_rev_v        <= 1'b1;
                            r_state        <= S_RESP;
                        end else begin
                            r_ret.pkt_type <= RET_LOAD;
                            if (w_legal) begin
                                r_state <= S_READ;
                            end else begin
                                r_rev_v <= 1'b1;
                                r_state <= S_RESP;
                            end
                        end
                    end
                end
                S_READ: begin
                    r_ret.data <= r_rdata;
                    r_rev_v    <= 1'b1;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    // Ready rises with the handshake so the next request lands one cycle later.
                    if (w_rev_ready) begin
                        r_rev_v     <= 1'b0;
                        r_fwd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_fwd_ready <= 1'b0;
                    r_rev_v     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept && w_legal) begin
            if (w_is_store) begin
                for (int unsigned b = 0; b < mask_w_lp; b++) begin
                    if (w_req.mask[b])
                        r_mem[w_idx][b*8 +: 8] <= w_req.payload[b*8 +: 8];
                end
            end else begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

endmodule

// File: tb/tb_bsg_manycore_link_mem_responder.sv
// Directed + random scoreboard bench for bsg_manycore_link_mem_responder.
// A shadow memory predicts each response at request acceptance; a negedge monitor pops and compares.
module tb_bsg_manycore_link_mem_responder;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 32;
    localparam int FWD_W  = ADDR_W + 2 + 4 + 5 + DATA_W + 16;
    localparam int RET_W  = 2 + DATA_W + 5 + 16;
    localparam int LINK_W = FWD_W + 2 + RET_W + 2;
    localparam logic [3:0] MY_X = 4'd5;
    localparam logic [3:0] MY_Y = 4'd9;

    typedef struct {
        logic [1:0]  t;
        logic [31:0] data;
        logic [4:0]  rid;
        logic [3:0]  dx;
        logic [3:0]  dy;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_ni;
    logic [LINK_W-1:0] link_sif_i;
    logic [LINK_W-1:0] link_sif_o;
    logic [15:0]       err_count_o;

    logic              fwd_v;
    logic [FWD_W-1:0]  fwd_pkt;
    logic              rev_ready;
    logic              bp_en;

    logic              fwd_ready, fwd_v_o, rev_v, rev_ready_o;
    logic [RET_W-1:0]  ret;

    exp_t              q[$];
    logic [31:0]       shadow [1024];
    int                exp_err;
    int                n_cmp, n_fail;
    int                n_req, n_resp;

    assign link_sif_i  = {fwd_v, 1'b1, fwd_pkt, 1'b0, rev_ready, {RET_W{1'b0}}};
    assign fwd_v_o     = link_sif_o[LINK_W-1];
    assign fwd_ready   = link_sif_o[LINK_W-2];
    assign rev_v       = link_sif_o[RET_W+1];
    assign rev_ready_o = link_sif_o[RET_W];
    assign ret         = link_sif_o[RET_W-1:0];

    bsg_manycore_link_mem_responder #(
        .addr_width_p  (ADDR_W),
        .data_width_p  (DATA_W),
        .x_cord_width_p(4),
        .y_cord_width_p(4),
        .els_p         (1024)
    ) dut (
        .clk_i      (clk),
        .reset_ni   (reset_ni),
        .link_sif_i (link_sif_i),
        .link_sif_o (link_sif_o),
        .my_x_i     (MY_X),
        .my_y_i     (MY_Y),
        .err_count_o(err_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FWD_W-1:0] mk_pkt(input logic st, input logic [27:0] a,
            input logic [3:0] m, input logic [4:0] r, input logic [31:0] d,
            input logic [3:0] sx, input logic [3:0] sy);
        return {a, (st ? 2'd1 : 2'd0), m, r, d, sy, sx, MY_Y, MY_X};
    endfunction

    // Called at posedge+1; returns at posedge+1 of the accepting edge with expectation pushed.
    task automatic send(input logic st, input logic [27:0] a, input logic [3:0] m,
            input logic [31:0] d, input logic [4:0] r, input logic [3:0] sx, input logic [3:0] sy);
        exp_t e;
        logic ok;
        logic legal;
        fwd_pkt = mk_pkt(st, a, m, r, d, sx, sy);
        fwd_v   = 1'b1;
        ok      = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (bp_en) rev_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (fwd_ready === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
        end
        fwd_v = 1'b0;
        chk("accepted", ok, 1);
        if (ok) begin
            n_req++;
            legal = (a < 28'd1024);
            if (!legal && exp_err < 65535) exp_err++;
            e.rid = r; e.dx = sx; e.dy = sy;
            if (st) begin
                e.t = 2'd1; e.data = 32'h0;
                if (legal)
                    for (int b = 0; b < 4; b++)
                        if (m[b]) shadow[a[9:0]][b*8 +: 8] = d[b*8 +: 8];
            end else begin
                e.t = 2'd0;
                e.data = legal ? shadow[a[9:0]] : 32'h0;
            end
            q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && q.size() != 0; i++) begin
            if (bp_en) rev_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (reset_ni === 1'b1 && rev_v === 1'b1 && rev_ready === 1'b1) begin
            n_resp++;
            if (q.size() == 0) begin
                chk("unexpected_resp", rev_v, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp", ret, {e.t, e.data, e.rid, MY_Y, MY_X, e.dy, e.dx});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_ni = 1'b0; fwd_v = 1'b0; fwd_pkt = '0; rev_ready = 1'b1; bp_en = 1'b0;
        exp_err = 0; n_cmp = 0; n_fail = 0; n_req = 0; n_resp = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rev_v", rev_v, 0);
        chk("rst_fwd_ready", fwd_ready, 0);
        chk("rst_err", err_count_o, 0);
        chk("fwd_v_o_tied", fwd_v_o, 0);
        chk("rev_ready_o_tied", rev_ready_o, 1);
        @(posedge clk); #1;
        reset_ni = 1'b1;

        for (int i = 0; i < 1024; i++)
            send(1, 28'(i), 4'hF, 32'hC0DE0000 ^ (i * 32'h00010101), 5'(i), 4'(i), 4'(i >> 4));
        drain();

        // Store then load, with latency checks
        send(1, 28'd5, 4'hF, 32'hDEADBEEF, 5'd3, 4'd2, 4'd1);
        chk("store_lat", rev_v, 1);
        drain();
        send(0, 28'd5, 4'hF, 32'h0, 5'd3, 4'd2, 4'd1);
        chk("load_lat_1", rev_v, 0);
        @(posedge clk); #1;
        chk("load_lat_2", rev_v, 1);
        chk("load_data_5", ret[52:21], 32'hDEADBEEF);
        drain();

        // Byte-masked merge and all-zero mask
        send(1, 28'd7, 4'hF, 32'h11223344, 5'd1, 4'd0, 4'd0);
        send(1, 28'd7, 4'b0101, 32'hAABBCCDD, 5'd2, 4'd0, 4'd0);
        send(0, 28'd7, 4'hF, 32'h0, 5'd4, 4'd0, 4'd0);
        @(posedge clk); #1;
        chk("merge_data_7", ret[52:21], 32'h11BB33DD);
        send(1, 28'd9, 4'h0, 32'hFFFFFFFF, 5'd5, 4'd3, 4'd3);
        send(0, 28'd9, 4'hF, 32'h0, 5'd6, 4'd3, 4'd3);
        drain();

        // Out-of-range accesses
        send(0, 28'd1024, 4'hF, 32'h0, 5'd7, 4'd1, 4'd2);
        chk("oor_load_direct", rev_v, 1);
        drain();
        chk("err_after_load", err_count_o, 1);
        send(1, 28'd2000, 4'hF, 32'h99999999, 5'd8, 4'd1, 4'd2);
        drain();
        chk("err_after_store", err_count_o, 2);
        send(0, 28'd0, 4'hF, 32'h0, 5'd9, 4'd1, 4'd2);
        send(0, 28'd1023, 4'hF, 32'h0, 5'd10, 4'd1, 4'd2);
        send(0, 28'd976, 4'hF, 32'h0, 5'd11, 4'd1, 4'd2);
        drain();

        // Long backpressure on a load response
        rev_ready = 1'b0;
        send(0, 28'd5, 4'hF, 32'h0, 5'd12, 4'd6, 4'd7);
        @(posedge clk); #1;
        fwd_pkt = mk_pkt(1, 28'd11, 4'hF, 5'd13, 32'h55AA55AA, 4'd6, 4'd7);
        fwd_v = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_rev_v", rev_v, 1);
            chk("stall_data", ret[52:21], 32'hDEADBEEF);
            chk("stall_fwd_ready", fwd_ready, 0);
        end
        @(posedge clk); #1;
        rev_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_rev_v", rev_v, 0);
        chk("release_fwd_ready", fwd_ready, 1);
        send(1, 28'd11, 4'hF, 32'h55AA55AA, 5'd13, 4'd6, 4'd7);
        chk("next_accept_ack", rev_v, 1);
        drain();

        // Random traffic with random response backpressure
        bp_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            logic [27:0] a;
            a = ($urandom_range(0, 7) == 0) ? 28'($urandom_range(1024, 4095))
                                            : 28'($urandom_range(0, 63));
            send(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, 5'($urandom),
                 4'($urandom), 4'($urandom));
        end
        drain();
        bp_en = 1'b0; rev_ready = 1'b1;
        chk("rand_err_count", err_count_o, 16'(exp_err));
        chk("resp_count", n_resp, n_req);

        // Reset while in READ
        rev_ready = 1'b0;
        send(0, 28'd5, 4'hF, 32'h0, 5'd14, 4'd1, 4'd1);
        reset_ni = 1'b0;
        #1;
        chk("rst_read_rev_v", rev_v, 0);
        chk("rst_read_err", err_count_o, 0);
        chk("rst_read_fwd_ready", fwd_ready, 0);
        q.delete(); exp_err = 0;
        @(posedge clk); #1;
        reset_ni = 1'b1;
        rev_ready = 1'b1;
        for (int i = 0; i < 10 && fwd_ready !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        chk("post_rst_ready", fwd_ready, 1);
        chk("post_rst_rev_v", rev_v, 0);

        // Reset while in RESP holding a store ack
        rev_ready = 1'b0;
        send(1, 28'd20, 4'hF, 32'h12345678, 5'd15, 4'd2, 4'd2);
        chk("pre_rst_resp", rev_v, 1);
        @(negedge clk);
        reset_ni = 1'b0;
        #1;
        chk("rst_resp_rev_v", rev_v, 0);
        chk("rst_resp_err", err_count_o, 0);
        q.delete();
        @(posedge clk); #1;
        reset_ni = 1'b1;
        rev_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale_resp", rev_v, 0);
        end
        @(posedge clk); #1;
        send(0, 28'd20, 4'hF, 32'h0, 5'd16, 4'd2, 4'd2);
        drain();
        chk("final_err", err_count_o, 16'(exp_err));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bsg_manycore_link_mem_responder.md
Name: bsg_manycore_link_mem_responder

Overview:
- Memory endpoint for one manycore cache-row link port, i.e. the north or south edge port where a victim cache normally attaches.
- Receives forward-network request packets (load/store) from tiles or the host loader.
- Services each request from an internal word-addressed SRAM and returns one reverse-network response per request.
- Used as a cache-less backing store for simulation/bring-up, and as the checker target for edge-link traffic.

Parameters:
- addr_width_p, 28: packet address width (words).
- data_width_p, 32: data width; mask width = data_width_p/8.
- x_cord_width_p, 4: x coordinate width.
- y_cord_width_p, 4: y coordinate width.
- els_p, 1024: SRAM depth in words; legal word addresses 0..els_p-1.
- link_sif_width_lp, derived: standard manycore link_sif width from the four widths above.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous active-low reset.
- link_sif_i  in  link_sif_width_lp  packed link_sif from the mesh (fwd request in, rev ready in).
- link_sif_o  out  link_sif_width_lp  packed link_sif to the mesh (fwd ready out, rev response out).
- my_x_i  in  x_cord_width_p  this endpoint's x coordinate, static after reset.
- my_y_i  in  y_cord_width_p  this endpoint's y coordinate, static after reset.
- err_count_o  out  16  count of out-of-range requests, saturating.

Behaviour:
- Interface: one clock, clk_i. reset_ni is asynchronous and active-low.
- Reset values: FSM=IDLE; fwd ready_o=0 while reset asserted; rev v_o=0; err_count_o=0. SRAM contents not reset.
- Unused directions:
  - Outgoing fwd v_o tied 0.
  - Incoming rev ready_o tied 1; any rev packet arriving is discarded.
- Forward handshake: a request transfers on a cycle with fwd v_i & fwd ready_o. fwd ready_o=1 only in IDLE.
- Reverse handshake: rev v_o is held with stable data until rev ready_and_i=1; the transfer occurs on that cycle.
- FSM:
  - IDLE, store accepted, address legal:
    - Write payload into SRAM[addr] with byte mask; unmasked bytes unchanged.
    - Build write-ack response -> RESP.
  - IDLE, load accepted, address legal:
    - Issue SRAM read -> READ.
  - READ: next cycle, latch read data into a load-data response -> RESP.
  - RESP: rev v_o=1. When rev ready_and_i=1 -> IDLE.
- Response fields:
  - dst = request src_x/src_y.
  - reg_id copied from the request.
  - src = my_x_i/my_y_i.
  - Type: write-ack for stores, load-data for loads.
- Latency:
  - Store: response valid the cycle after acceptance.
  - Load: response valid 2 cycles after acceptance.
  - Best-case throughput: store 1 per 2 cycles, load 1 per 3 cycles.
- Out of range (addr >= els_p, compared at full addr_width_p):
  - Store: dropped, ack still returned.
  - Load: returns data 0 and skips READ (IDLE->RESP directly).
  - Both: err_count_o increments, saturating at 16'hFFFF.
- Backpressure:
  - Response may stall indefinitely in RESP.
  - Further requests see ready_o=0; no request is lost or duplicated.
- Simultaneous events:
  - Rev handshake completes in RESP while fwd v_i=1: the request is not accepted that cycle. Acceptance happens the following cycle in IDLE.
- Reset mid-operation:
  - Any in-flight request or pending response is discarded.
  - A store already written stays written.
  - err_count_o clears.
- Coordinates are sampled into the response at build time; changing my_x_i/my_y_i mid-operation is illegal.
- Byte mask of all zeros on a store: no SRAM change, ack returned.

Test Plan:
- Store 0xDEADBEEF mask 4'hF to addr 5, src (2,1), reg_id 3 -> one ack the next cycle: dst (2,1), reg_id 3, src=(my_x_i,my_y_i). Then load addr 5 -> load-data 0xDEADBEEF, 2 cycles after acceptance.
- Store 0x11223344 mask 4'hF, then 0xAABBCCDD mask 4'b0101 to addr 7 -> load addr 7 returns 0x11BB33DD.
- Load addr els_p (1024) -> data 0 returned; err_count_o=1. Store to 2000 -> ack returned, err_count_o=2, SRAM unchanged (spot-check addr 0 and 1023).
- Hold rev ready_and_i=0 for 20 cycles after a load -> rev v_o stays 1 with constant data, fwd ready_o stays 0. Release -> exactly one response; next request accepted the following cycle.
- Back-to-back 64 random stores/loads with random rev backpressure, checked against a scoreboard -> responses in order, count = request count, all data matches.
- Assert reset_ni low in READ and in RESP -> rev v_o drops asynchronously, err_count_o=0. After release, FSM in IDLE and the prior pending response is never emitted.
